code_detonator_ctrl: RTL

Parametrised successor of the 4-digit numeric code detonator controller. Keypad digit-code entry with configurable digit count, retry limit with timed lockout, runtime code change after successful authentication, and a timed fire pulse. Sits between the debounced panel inputs (mode buttons, 10-key active-low keypad) and the panel lamps and digit display.

---
 rtl/code_detonator_ctrl_pkg.sv | 28 ++
 rtl/code_detonator_ctrl_key_event.sv | 24 ++
 rtl/code_detonator_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/code_detonator_ctrl_pkg.sv
// Shared types and helpers for the keypad code detonator controller.
package code_det_pkg;

   typedef enum logic [3:0] {
      ST_WAIT,
      ST_READY,
      ST_INPUT,
      ST_CHECK,
      ST_OK,
      ST_FIRE,
      ST_ERROR,
      ST_LOCK,
      ST_SETUP
   } state_e;

   localparam logic [9:0] NO_KEY = 10'h3FF;

   // Lowest active-low bit wins; callers only use the result for single-key patterns.
   function automatic logic [3:0] key_to_bcd(input logic [9:0] a);
      logic [3:0] d;
      d = 4'd0;
      for (int i = 9; i >= 0; i--) begin
         if (!a[i]) d = 4'(i);
      end
      return d;
   endfunction

endpackage

// File: rtl/code_detonator_ctrl_key_event.sv
// Keypad edge detector: one pulse per fresh single-key press, multi-key patterns rejected.
module key_event
   import code_det_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] a_i,
   output logic       key_valid_o,
   output logic [3:0] digit_o
);

   logic [9:0] prev_q;
   logic       single_key;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_q <= NO_KEY;
      else      prev_q <= a_i;
   end

   assign single_key  = ($countones(~a_i) == 1);
   assign key_valid_o = single_key && (prev_q == NO_KEY);
   assign digit_o     = key_to_bcd(a_i);

endmodule

// File: rtl/code_detonator_ctrl.sv
// Code entry / authentication / fire controller with retry lockout and runtime code change.
module code_detonator_ctrl
   import code_det_pkg::*;
#(
   parameter int                 DIGITS      = 4,
   parameter logic [4*DIGITS-1:0] INIT_CODE  = 16'h2580,
   parameter int                 MAX_TRIES   = 3,
   parameter int                 LOCK_CYCLES = 1000,
   parameter int                 FIRE_CYCLES = 50
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wait_t,
   input  logic                           setup,
   input  logic                           ready,
   input  logic                           fire,
   input  logic                           sure,
   input  logic [9:0]                     A,
   output logic                           lt,
   output logic                           bt,
   output logic                           rt,
   output logic                           lb,
   output logic [3:0]                     m_disp,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
   output logic                           locked
);

   localparam int CW    = 4 * DIGITS;
   localparam int NW    = $clog2(DIGITS + 1);
   localparam int TW    = $clog2(MAX_TRIES + 1);
   localparam int MAXC  = (LOCK_CYCLES > FIRE_CYCLES) ? LOCK_CYCLES : FIRE_CYCLES;
   localparam int CNTW  = $clog2(MAXC + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   code_q, code_d;
   logic [CW-1:0]   entry_q, entry_d;
   logic [NW-1:0]   count_q, count_d;
   logic [TW-1:0]   tries_q, tries_d;
   logic [CNTW-1:0] timer_q, timer_d;
   logic [3:0]      disp_q, disp_d;
   logic            lt_q, bt_q, rt_q, lb_q, locked_q;

   logic            key_valid;
   logic [3:0]      key_digit;
   logic            accept;
   logic            full;

   key_event u_key_event (
      .clk         (clk),
      .rst         (rst),
      .a_i         (A),
      .key_valid_o (key_valid),
      .digit_o     (key_digit)
   );

   assign full = (count_q == NW'(DIGITS));

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      entry_d = entry_q;
      count_d = count_q;
      tries_d = tries_q;
      timer_d = timer_q;
      disp_d  = disp_q;
      accept  = 1'b0;

      case (state_q)
         ST_WAIT: begin
            if (fire)       state_d = ST_ERROR;
            else if (ready) state_d = ST_READY;
         end
         ST_READY: begin
            if (fire || sure)   state_d = ST_ERROR;
            else if (wait_t)    state_d = ST_WAIT;
            else if (key_valid) begin
               accept  = 1'b1;
               state_d = ST_INPUT;
            end
         end
         ST_INPUT: begin
            if (fire)           state_d = ST_ERROR;
            else if (wait_t)    state_d = ST_WAIT;
            else if (sure)      state_d = full ? ST_CHECK : ST_ERROR;
            else if (key_valid) begin
               if (full) state_d = ST_ERROR;
               else      accept  = 1'b1;
            end
         end
         ST_CHECK: begin
            if (entry_q == code_q) begin
               state_d = ST_OK;
               tries_d = TW'(MAX_TRIES);
            end else begin
               tries_d = tries_q - 1'b1;
               if (tries_q <= TW'(1)) begin
                  state_d = ST_LOCK;
                  timer_d = CNTW'(LOCK_CYCLES - 1);
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_ERROR: begin
            if (wait_t) state_d = ST_WAIT;
         end
         ST_OK: begin
            if (fire) begin
               state_d = ST_FIRE;
               timer_d = CNTW'(FIRE_CYCLES - 1);
            end else if (wait_t) begin
               state_d = ST_WAIT;
            end else if (setup) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (fire || wait_t) begin
               state_d = ST_WAIT;
            end else if (sure) begin
               if (full) begin
                  code_d  = entry_q;
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_ERROR;
               end
            end else if (key_valid) begin
               if (full) state_d = ST_ERROR;
               else      accept  = 1'b1;
            end
         end
         ST_FIRE: begin
            if (timer_q == '0) state_d = ST_WAIT;
            else               timer_d = timer_q - 1'b1;
         end
         ST_LOCK: begin
            if (timer_q == '0) begin
               state_d = ST_WAIT;
               tries_d = TW'(MAX_TRIES);
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = ST_WAIT;
      endcase

      // Shift in the new digit; the cast drops the oldest digit off the top.
      if (accept) begin
         entry_d = CW'({entry_q, key_digit});
         count_d = count_q + 1'b1;
         disp_d  = key_digit;
      end

      if (((state_d == ST_READY || state_d == ST_SETUP) && state_d != state_q) ||
          state_q == ST_ERROR) begin
         entry_d = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_WAIT;
         code_q   <= INIT_CODE;
         entry_q  <= '0;
         count_q  <= '0;
         tries_q  <= TW'(MAX_TRIES);
         timer_q  <= '0;
         disp_q   <= 4'd0;
         lt_q     <= 1'b0;
         bt_q     <= 1'b0;
         rt_q     <= 1'b0;
         lb_q     <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         entry_q  <= entry_d;
         count_q  <= count_d;
         tries_q  <= tries_d;
         timer_q  <= timer_d;
         disp_q   <= disp_d;
         lt_q     <= (state_q == ST_READY) || (state_q == ST_INPUT) || (state_q == ST_SETUP);
         bt_q     <= (state_q == ST_ERROR) || (state_q == ST_LOCK);
         rt_q     <= (state_q == ST_OK);
         lb_q     <= (state_q == ST_FIRE);
         locked_q <= (state_q == ST_LOCK);
      end
   end

   assign lt         = lt_q;
   assign bt         = bt_q;
   assign rt         = rt_q;
   assign lb         = lb_q;
   assign locked     = locked_q;
   assign m_disp     = disp_q;
   assign tries_left = tries_q;

endmodule
